result_writer: RTL
==================

Name: result_writer

Overview:
- Back-end consumer of the probe engine's join-result FIFO.
- Pops (dim, fact) match pairs and writes each pair as two consecutive 64-bit words to a contiguous result buffer in coprocessor memory, through a write-request/write-response port.
- Tracks outstanding writes and raises done only when the engine is finished, the FIFO is drained and every write is acknowledged.
- Sits between the engine's output FIFO interface and a memory-controller write port.

Parameters:
- MAX_OUTSTANDING, 32, maximum write requests accepted but not yet acknowledged (1..255).
- CNT_W, 8, width of the outstanding-write counter; must hold MAX_OUTSTANDING.

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst  in  1  reset, asynchronous, active-low.
- done  out  1  sticky completion flag.
- out_base_in  in  48  byte address of the result buffer; 16-byte aligned; held stable while rst is high.
- max_pairs_in  in  64  buffer capacity in pairs.
- engine_done_in  in  1  upstream engine has produced its last pair.
- fifo_empty_in  in  1  result FIFO empty (first-word-fall-through).
- fifo_read_en_out  out  1  pop strobe; data is consumed in the same cycle.
- fifo_dim_in  in  64  dim-table value at the FIFO head.
- fifo_fact_in  in  64  fact-table value at the FIFO head.
- wr_rq_stall_in  in  1  memory cannot accept a request this cycle.
- wr_rq_vld_out  out  1  write request valid.
- wr_rq_vadr_out  out  48  write byte address.
- wr_rq_data_out  out  64  write data.
- wr_rs_vld_in  in  1  one write acknowledged.
- pairs_written_out  out  64  pairs fully issued to memory.
- overflow_out  out  1  at least one pair was discarded because the buffer was full.

Behaviour:

Reset values:
- While rst=0, all of the following are 0: state=IDLE, done, fifo_read_en_out, wr_rq_vld_out, wr_rq_vadr_out, wr_rq_data_out, pairs_written_out, overflow_out, the outstanding counter, and the held pair registers.

State machine (IDLE, FETCH, WR_DIM, WR_FACT, DRAIN, FINISH):
- IDLE -> FETCH unconditionally on the first cycle after reset release.
- FETCH, with !fifo_empty_in and pairs_written_out < max_pairs_in:
  - Assert fifo_read_en_out combinationally.
  - Latch fifo_dim_in and fifo_fact_in.
  - Go to WR_DIM.
- FETCH, with !fifo_empty_in and pairs_written_out >= max_pairs_in:
  - Assert fifo_read_en_out and discard the pair.
  - Set overflow_out (sticky).
  - Stay in FETCH.
- FETCH, with fifo_empty_in and engine_done_in: go to DRAIN. Empty has priority over a simultaneous engine_done_in only in the sense that both must hold.
- WR_DIM:
  - wr_rq_vld_out = 1 when outstanding < MAX_OUTSTANDING, else 0.
  - Address = out_base_in + 16*pairs_written_out; data = latched dim.
  - Accepted when vld && !wr_rq_stall_in; on acceptance go to WR_FACT.
- WR_FACT:
  - Same rule as WR_DIM, with address + 8 and data = latched fact.
  - On acceptance, pairs_written_out increments and the state returns to FETCH.
- DRAIN: wait until outstanding == 0, then go to FINISH.
- FINISH: done = 1, held until reset. No further FIFO pops or requests.

Address arithmetic:
- 48-bit modulo.
- pairs_written_out is truncated to 44 bits before the shift by 4.

Outstanding counter:
- +1 per accepted request, −1 per wr_rs_vld_in; unchanged when both happen in the same cycle.
- Never exceeds MAX_OUTSTANDING.
- A wr_rs_vld_in arriving while the counter is 0 is ignored (counter saturates at 0).

Timing:
- Minimum latency from FIFO pop to first request: 1 cycle.
- Minimum rate: 1 pair per 3 cycles.
- Request outputs are combinational from registered state and data. Address and data stay stable while stall is asserted.

Mid-operation reset:
- Asserting rst at any point returns every output to its reset value immediately.
- Partially written pairs are abandoned.

Optional Feature:
- Macro: RESULT_WRITER_COUNT_HDR_EN
- Defined:
  - Extra state HDR between DRAIN and FINISH.
  - HDR issues one further write: address out_base_in − 8, data = pairs_written_out, under the same stall and outstanding rules.
  - After acceptance, wait for outstanding == 0, then go to FINISH.
- Not defined: DRAIN goes directly to FINISH and no header write is issued.

Test Plan:
- Base 0x1000, max 8, three pairs (1,A),(2,B),(3,C), no stall, then engine_done_in -> writes in order:
  - 0x1000=1, 0x1008=A
  - 0x1010=2, 0x1018=B
  - 0x1020=3, 0x1028=C
  - pairs_written_out=3, then done=1 after 6 acks.
- Stall held for 5 cycles during WR_FACT of pair 0 -> wr_rq_vadr_out holds 0x1008 with data A for the whole stall; exactly 6 requests are accepted in total.
- max_pairs_in=2 with 4 pairs -> 4 entries are popped, only 4 writes are issued, overflow_out=1, pairs_written_out=2, done=1.
- MAX_OUTSTANDING=2, acks withheld -> wr_rq_vld_out drops after 2 accepted requests; it resumes one cycle after each ack; a simultaneous accept and ack leaves the counter unchanged.
- rst pulsed low in WR_DIM of pair 1 -> all outputs 0 immediately; after release, 2 new pairs are written starting at the base address.
- With RESULT_WRITER_COUNT_HDR_EN, 3 pairs at base 0x1000 -> final request is 0x0FF8=3, and done asserts only after its ack.

Source files
------------

// File: rtl/result_writer.sv
// result_writer: drains the probe engine's join-result FIFO. Each (dim, fact)
// pair becomes two consecutive 64-bit writes into a contiguous result buffer.
// It tracks outstanding writes and raises a sticky done once everything is
// written and acknowledged.
// Optional feature macro: RESULT_WRITER_COUNT_HDR_EN. When it is defined, a
// pair-count header word is written at out_base_in - 8 before done.
module result_writer #(
    parameter int unsigned MAX_OUTSTANDING = 32,
    parameter int unsigned CNT_W           = 8
) (
    input  logic        clk,
    input  logic        rst,
    output logic        done,
    input  logic [47:0] out_base_in,
    input  logic [63:0] max_pairs_in,
    input  logic        engine_done_in,
    input  logic        fifo_empty_in,
    output logic        fifo_read_en_out,
    input  logic [63:0] fifo_dim_in,
    input  logic [63:0] fifo_fact_in,
    input  logic        wr_rq_stall_in,
    output logic        wr_rq_vld_out,
    output logic [47:0] wr_rq_vadr_out,
    output logic [63:0] wr_rq_data_out,
    input  logic        wr_rs_vld_in,
    output logic [63:0] pairs_written_out,
    output logic        overflow_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WR_DIM,
        S_WR_FACT,
        S_DRAIN,
        S_HDR,
        S_FINISH
    } state_t;

    state_t            state_q, state_d;
    logic [63:0]       dim_q, dim_d;
    logic [63:0]       fact_q, fact_d;
    logic [63:0]       pairs_q, pairs_d;
    logic              ovf_q, ovf_d;
    logic [CNT_W-1:0]  outst_q, outst_d;
`ifdef RESULT_WRITER_COUNT_HDR_EN
    logic              hdr_sent_q, hdr_sent_d;
`endif

    logic              can_issue;
    logic              accept;
    logic              ack_eff;
    logic [47:0]       pair_adr;

    // Issue is throttled by the number of writes still waiting for a response.
    assign can_issue = (outst_q < CNT_W'(MAX_OUTSTANDING));
    assign accept    = wr_rq_vld_out && !wr_rq_stall_in;
    // A response with nothing outstanding is spurious; the counter saturates at zero.
    assign ack_eff   = wr_rs_vld_in && (outst_q != '0);
    // Slot address of the current pair: only the low 44 bits of the count shift into 48 bits.
    assign pair_adr  = out_base_in + {pairs_q[43:0], 4'b0000};

    assign pairs_written_out = pairs_q;
    assign overflow_out      = ovf_q;

    // Outstanding-write counter: requests accepted minus responses received.
    always_comb begin
        outst_d = outst_q;
        if (accept && !ack_eff) begin
            outst_d = outst_q + CNT_W'(1);
        end else if (!accept && ack_eff) begin
            outst_d = outst_q - CNT_W'(1);
        end
    end

    // Next-state logic and combinational FIFO-pop / write-request outputs.
    always_comb begin
        state_d          = state_q;
        dim_d            = dim_q;
        fact_d           = fact_q;
        pairs_d          = pairs_q;
        ovf_d            = ovf_q;
`ifdef RESULT_WRITER_COUNT_HDR_EN
        hdr_sent_d       = hdr_sent_q;
`endif
        fifo_read_en_out = 1'b0;
        wr_rq_vld_out    = 1'b0;
        wr_rq_vadr_out   = '0;
        wr_rq_data_out   = '0;
        done             = 1'b0;
        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                if (!fifo_empty_in) begin
                    fifo_read_en_out = 1'b1;
                    if (pairs_q < max_pairs_in) begin
                        dim_d   = fifo_dim_in;
                        fact_d  = fifo_fact_in;
                        state_d = S_WR_DIM;
                    end else begin
                        // The buffer is full: the pair is popped and dropped.
                        ovf_d = 1'b1;
                    end
                end else if (engine_done_in) begin
                    state_d = S_DRAIN;
                end
            end
            S_WR_DIM: begin
                wr_rq_vld_out  = can_issue;
                wr_rq_vadr_out = pair_adr;
                wr_rq_data_out = dim_q;
                if (can_issue && !wr_rq_stall_in) begin
                    state_d = S_WR_FACT;
                end
            end
            S_WR_FACT: begin
                wr_rq_vld_out  = can_issue;
                wr_rq_vadr_out = pair_adr + 48'd8;
                wr_rq_data_out = fact_q;
                if (can_issue && !wr_rq_stall_in) begin
                    pairs_d = pairs_q + 64'd1;
                    state_d = S_FETCH;
                end
            end
            S_DRAIN: begin
                if (outst_q == '0) begin
`ifdef RESULT_WRITER_COUNT_HDR_EN
                    state_d = S_HDR;
`else
                    state_d = S_FINISH;
`endif
                end
            end
`ifdef RESULT_WRITER_COUNT_HDR_EN
            S_HDR: begin
                // One header write holding the pair count, then wait for every response.
                wr_rq_vld_out  = can_issue && !hdr_sent_q;
                wr_rq_vadr_out = out_base_in - 48'd8;
                wr_rq_data_out = pairs_q;
                if (can_issue && !hdr_sent_q && !wr_rq_stall_in) begin
                    hdr_sent_d = 1'b1;
                end
                if (hdr_sent_q && (outst_q == '0)) begin
                    state_d = S_FINISH;
                end
            end
`endif
            S_FINISH: begin
                done = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously by the active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            dim_q      <= '0;
            fact_q     <= '0;
            pairs_q    <= '0;
            ovf_q      <= 1'b0;
            outst_q    <= '0;
`ifdef RESULT_WRITER_COUNT_HDR_EN
            hdr_sent_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            dim_q      <= dim_d;
            fact_q     <= fact_d;
            pairs_q    <= pairs_d;
            ovf_q      <= ovf_d;
            outst_q    <= outst_d;
`ifdef RESULT_WRITER_COUNT_HDR_EN
            hdr_sent_q <= hdr_sent_d;
`endif
        end
    end

endmodule
